protobuf_byte_packer: RTL and testbench

PROTOBUF_BYTE_PACKER -- requirements
Module: protobuf_byte_packer

---
 rtl/protobuf_byte_packer.sv | 150 +++++++++++++++
 tb/tb_protobuf_byte_packer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/protobuf_byte_packer.sv
// Packs a serialized protobuf byte stream into little-endian 32-bit words
// with byte-lane keeps, and tracks per-message length and overflow.
module protobuf_byte_packer #(
    parameter int unsigned MAX_BYTES = 1024
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] msg_len,
    output logic        msg_done,
    output logic        err_overflow
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  msg_len_q, msg_len_d;
    logic              msg_done_q, msg_done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              complete;
    logic              pop;
    logic [WORD_W-1:0] merged;
    logic [3:0]        lane_keep;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_at_max;

    // Stall the input only while a pending word is refused downstream.
    assign in_ready = ~(out_valid_q & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign complete = accept & ((lane_q == 2'd3) | in_last);
    assign pop      = out_valid_q & out_ready;

    // Upper lanes of the accumulator are always zero, so OR-ing inserts the byte.
    assign merged = acc_q | (WORD_W'(in_data) << {lane_q, 3'b000});

    assign cnt_at_max = (cnt_q == MAX_CNT);
    assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + CNT_W'(1);

    // Keep mask covering lanes 0..lane of the completing byte.
    always_comb begin
        lane_keep = 4'b0001;
        case (lane_q)
            2'd0: lane_keep = 4'b0001;
            2'd1: lane_keep = 4'b0011;
            2'd2: lane_keep = 4'b0111;
            2'd3: lane_keep = 4'b1111;
            default: lane_keep = 4'b0001;
        endcase
    end

    // Lane/accumulator advance and output-register load or drain.
    always_comb begin
        lane_d      = lane_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (complete) begin
            out_data_d  = merged;
            out_keep_d  = lane_keep;
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            lane_d      = 2'd0;
            acc_d       = '0;
        end else begin
            if (accept) begin
                acc_d  = merged;
                lane_d = lane_q + 2'd1;
            end
            if (pop) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Saturating message byte counter, length latch and sticky overflow.
    always_comb begin
        cnt_d      = cnt_q;
        msg_len_d  = msg_len_q;
        msg_done_d = 1'b0;
        err_d      = err_q;
        if (accept) begin
            if (cnt_at_max) begin
                err_d = 1'b1;
            end
            if (in_last) begin
                msg_len_d  = cnt_inc;
                msg_done_d = 1'b1;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            lane_q      <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            msg_len_q   <= '0;
            msg_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            msg_len_q   <= msg_len_d;
            msg_done_q  <= msg_done_d;
            err_q       <= err_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_keep     = out_keep_q;
    assign out_last     = out_last_q;
    assign out_valid    = out_valid_q;
    assign msg_len      = msg_len_q;
    assign msg_done     = msg_done_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_protobuf_byte_packer.sv
// Bench for protobuf_byte_packer: directed table, multi-cycle corner cases
// and randomized traffic against a byte-grouping reference model.
module tb_protobuf_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, in_ready_b;
    logic [31:0] out_data, out_data_b;
    logic [3:0]  out_keep, out_keep_b;
    logic        out_valid, out_valid_b;
    logic        out_last, out_last_b;
    logic [15:0] msg_len, msg_len_b;
    logic        msg_done, msg_done_b;
    logic        err_overflow, err_overflow_b;

    localparam int MAX_A = 1024;
    localparam int MAX_B = 4;

    always #5 clk = ~clk;

    protobuf_byte_packer dut_a (
        .clock_clk(clk), .reset_reset(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .msg_len(msg_len), .msg_done(msg_done), .err_overflow(err_overflow)
    );

    protobuf_byte_packer #(.MAX_BYTES(MAX_B)) dut_b (
        .clock_clk(clk), .reset_reset(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_keep(out_keep_b), .out_valid(out_valid_b), .out_last(out_last_b),
        .out_ready(out_ready), .msg_len(msg_len_b), .msg_done(msg_done_b), .err_overflow(err_overflow_b)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        ov;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        done;
        logic [15:0] len;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    word_t      exp_q[$];
    logic [7:0] grp[$];
    int         msg_cnt;
    logic       exp_done;
    int         exp_len_a, exp_len_b;
    logic       exp_err_a, exp_err_b;
    logic       hold_prev;
    word_t      hold_word;
    int         pop_bytes;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(logic v, logic [7:0] d, logic l, logic ov, logic [31:0] data,
                                 logic [3:0] keep, logic last, logic done, logic [15:0] len);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.ov = ov; r.data = data;
        r.keep = keep; r.last = last; r.done = done; r.len = len;
        return r;
    endfunction

    // Model: bytes are grouped in order; a group closes at 4 bytes or on last.
    task automatic model_accept(input logic [7:0] d, input logic l);
        word_t w;
        grp.push_back(d);
        msg_cnt++;
        if (msg_cnt > MAX_A) exp_err_a = 1'b1;
        if (msg_cnt > MAX_B) exp_err_b = 1'b1;
        if (grp.size() == 4 || l) begin
            w.data = '0;
            for (int i = 0; i < grp.size(); i++) w.data[8*i +: 8] = grp[i];
            w.keep = 4'((1 << grp.size()) - 1);
            w.last = l;
            exp_q.push_back(w);
            grp.delete();
        end
        if (l) begin
            exp_done  = 1'b1;
            exp_len_a = (msg_cnt < MAX_A) ? msg_cnt : MAX_A;
            exp_len_b = (msg_cnt < MAX_B) ? msg_cnt : MAX_B;
            msg_cnt   = 0;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        grp.delete();
        msg_cnt   = 0;
        exp_done  = 1'b0;
        exp_len_a = 0;
        exp_len_b = 0;
        exp_err_a = 1'b0;
        exp_err_b = 1'b0;
        hold_prev = 1'b0;
    endtask

    // One clock: drive at negedge, evaluate handshakes, then check registered state after the edge.
    task automatic tick(input logic v, input logic [7:0] d, input logic l, input logic r, output logic acc);
        word_t cur;
        @(negedge clk);
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        cur = {out_data, out_keep, out_last};
        if (hold_prev) chk("hold_stable", 64'({out_valid, cur}), 64'({1'b1, hold_word}));
        chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        chk("in_ready_match", 64'(in_ready_b), 64'(in_ready));
        acc = v && in_ready;
        exp_done = 1'b0;
        if (out_valid && out_ready) begin
            chk("word_available", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("word", 64'(cur), 64'(exp_q.pop_front()));
            pop_bytes += $countones(out_keep);
        end
        hold_prev = out_valid && !out_ready;
        hold_word = cur;
        if (acc) model_accept(d, l);
        @(posedge clk);
        #1;
        chk("msg_a", 64'({msg_done, msg_len, err_overflow}), 64'({exp_done, 16'(exp_len_a), exp_err_a}));
        chk("msg_b", 64'({msg_done_b, msg_len_b, err_overflow_b}), 64'({exp_done, 16'(exp_len_b), exp_err_b}));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        chk("reset_state", 64'({out_valid, out_last, out_keep, out_data, msg_len, msg_done, err_overflow, in_ready}),
            64'({1'b0, 1'b0, 4'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1}));
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        logic a;
        int n;
        n = 0;
        a = 1'b0;
        while (!a && n < 50) begin
            tick(1'b1, d, l, 1'b1, a);
            n++;
        end
        chk("send_accepted", 64'(a), 64'd1);
    endtask

    initial begin
        vec_t       tbl[14];
        logic       a;
        logic [7:0] rbytes[1000];
        logic       rlasts[1000];
        int         rem, idx, cyc, n;
        logic       v, r;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        pop_bytes = 0;
        model_clear();

        tbl[0]  = mkv(1, 8'h08, 0, 0, 32'h0,        4'h0, 0, 0, 16'd0);
        tbl[1]  = mkv(1, 8'h96, 0, 0, 32'h0,        4'h0, 0, 0, 16'd0);
        tbl[2]  = mkv(1, 8'h01, 0, 0, 32'h0,        4'h0, 0, 0, 16'd0);
        tbl[3]  = mkv(1, 8'h12, 0, 1, 32'h12019608, 4'hF, 0, 0, 16'd0);
        tbl[4]  = mkv(1, 8'h07, 1, 1, 32'h00000007, 4'h1, 1, 1, 16'd5);
        tbl[5]  = mkv(0, 8'h00, 0, 0, 32'h0,        4'h0, 0, 0, 16'd5);
        tbl[6]  = mkv(1, 8'hA1, 0, 0, 32'h0,        4'h0, 0, 0, 16'd5);
        tbl[7]  = mkv(1, 8'hA2, 0, 0, 32'h0,        4'h0, 0, 0, 16'd5);
        tbl[8]  = mkv(1, 8'hA3, 1, 1, 32'h00A3A2A1, 4'h7, 1, 1, 16'd3);
        tbl[9]  = mkv(1, 8'hB1, 0, 0, 32'h0,        4'h0, 0, 0, 16'd3);
        tbl[10] = mkv(1, 8'hB2, 1, 1, 32'h0000B2B1, 4'h3, 1, 1, 16'd2);
        tbl[11] = mkv(0, 8'h00, 0, 0, 32'h0,        4'h0, 0, 0, 16'd2);
        tbl[12] = mkv(1, 8'hC5, 1, 1, 32'h000000C5, 4'h1, 1, 1, 16'd1);
        tbl[13] = mkv(0, 8'h00, 0, 0, 32'h0,        4'h0, 0, 0, 16'd1);

        repeat (2) @(posedge clk);
        do_reset();

        // Directed table: five-byte message, back-to-back 3/2 messages, single byte
        for (int i = 0; i < 14; i++) begin
            tick(tbl[i].v, tbl[i].d, tbl[i].l, 1'b1, a);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            if (tbl[i].ov)
                chk($sformatf("tbl%0d_word", i), 64'({out_data, out_keep, out_last}),
                    64'({tbl[i].data, tbl[i].keep, tbl[i].last}));
            chk($sformatf("tbl%0d_msg", i), 64'({msg_done, msg_len}), 64'({tbl[i].done, tbl[i].len}));
        end

        // Backpressure: eight bytes with the consumer initially stalled
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, a);
            chk("bp_fill_accept", 64'(a), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'h14, 1'b0, 1'b0, a);
            chk("bp_stall_accept", 64'(a), 64'd0);
            chk("bp_held_word", 64'({out_valid, out_data, out_keep, out_last}), 64'({1'b1, 32'h13121110, 4'hF, 1'b0}));
        end
        for (int i = 4; i < 8; i++) send(8'(8'h10 + i), i == 7);
        tick(1'b0, 8'h00, 1'b0, 1'b1, a);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Overflow on the MAX_BYTES=4 instance with a six-byte message
        do_reset();
        for (int i = 0; i < 4; i++) send(8'(8'hE0 + i), 1'b0);
        chk("ovf_before", 64'(err_overflow_b), 64'd0);
        send(8'hE4, 1'b0);
        chk("ovf_rise", 64'(err_overflow_b), 64'd1);
        send(8'hE5, 1'b1);
        chk("ovf_len", 64'({msg_len_b, msg_len}), 64'({16'd4, 16'd6}));
        tick(1'b0, 8'h00, 1'b0, 1'b1, a);
        chk("ovf_all_emitted", 64'(exp_q.size()), 64'd0);
        chk("ovf_sticky", 64'(err_overflow_b), 64'd1);

        // Reset discards a pending word and a partial word
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, a);
        chk("rst_pending_present", 64'(out_valid), 64'd1);
        do_reset();
        chk("rst_pending_dropped", 64'(out_valid), 64'd0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        do_reset();
        chk("rst_partial_dropped", 64'(out_valid), 64'd0);
        send(8'h71, 1'b0);
        send(8'h72, 1'b0);
        send(8'h73, 1'b1);
        chk("rst_repack_lane0", 64'({out_valid, out_data, out_keep, out_last}), 64'({1'b1, 32'h00737271, 4'h7, 1'b1}));
        tick(1'b0, 8'h00, 1'b0, 1'b1, a);

        // Random valid/ready traffic, 1000 bytes in messages of 1..9 bytes
        do_reset();
        rem = $urandom_range(1, 9);
        for (int i = 0; i < 1000; i++) begin
            rbytes[i] = 8'($urandom);
            rlasts[i] = (rem == 1) || (i == 999);
            rem = (rem == 1) ? $urandom_range(1, 9) : rem - 1;
        end
        pop_bytes = 0;
        idx = 0;
        cyc = 0;
        while (idx < 1000 && cyc < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            tick(v, rbytes[idx], rlasts[idx], r, a);
            if (a) idx++;
            cyc++;
        end
        chk("rand_all_accepted", 64'(idx), 64'd1000);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1, a);
            n++;
        end
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_byte_count", 64'(pop_bytes), 64'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
